param_square_root: RTL

PARAM_SQUARE_ROOT -- requirements
Module: param_square_root

---
 rtl/sqrt_pkg.sv | 20 ++
 rtl/sqrt_step.sv | 32 +++
 rtl/param_square_root.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/sqrt_pkg.sv
// Shared definitions for the iterative square-root block: FSM state encoding
// and helpers that derive iteration count and counter width from parameters.
package sqrt_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_CALC = 2'b01,
        ST_DONE = 2'b10
    } state_t;

    // Number of CALC cycles: each cycle consumes 2*bits_per_cycle radicand bits.
    function automatic int calc_iter(input int width, input int bits_per_cycle);
        return width / (2 * bits_per_cycle);
    endfunction

    function automatic int cnt_width(input int iter);
        return (iter < 2) ? 1 : $clog2(iter);
    endfunction

endpackage

// File: rtl/sqrt_step.sv
// One digit-recurrence step of the restoring square root: folds the next two
// radicand bits into the partial remainder and resolves one root bit.
module sqrt_step #(
    parameter int ROOT_W = 8,
    parameter int REM_W  = ROOT_W + 2
) (
    input  logic [REM_W-1:0]  rem_in,
    input  logic [ROOT_W-1:0] root_in,
    input  logic [1:0]        pair,
    output logic [REM_W-1:0]  rem_out,
    output logic [ROOT_W-1:0] root_out
);

    logic [REM_W+1:0] shifted;
    logic [REM_W+1:0] subtrahend;
    logic             fits;

    always_comb begin
        shifted    = {rem_in, pair};
        subtrahend = {{(REM_W - ROOT_W){1'b0}}, root_in, 2'b01};
        fits       = (shifted >= subtrahend);
        // The true remainder never exceeds 2*root, so REM_W bits always hold it.
        if (fits) begin
            rem_out  = REM_W'(shifted - subtrahend);
            root_out = {root_in[ROOT_W-2:0], 1'b1};
        end else begin
            rem_out  = shifted[REM_W-1:0];
            root_out = {root_in[ROOT_W-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/param_square_root.sv
// Iterative integer square root with valid/ready handshakes and flush.
// Optional remainder output is enabled by defining SQRT_REMAINDER_EN.
module param_square_root
    import sqrt_pkg::*;
#(
    parameter int WIDTH          = 16,
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid_i,
    output logic                 in_ready_o,
    input  logic [WIDTH-1:0]     valor_i,
    input  logic                 flush_i,
    output logic                 out_valid_o,
    input  logic                 out_ready_i,
    output logic [WIDTH/2-1:0]   root_o,
`ifdef SQRT_REMAINDER_EN
    output logic [WIDTH/2:0]     rem_o,
`endif
    output logic                 busy_o
);

    localparam int ROOT_W = WIDTH / 2;
    localparam int REM_W  = ROOT_W + 2;
    localparam int ITER   = calc_iter(WIDTH, BITS_PER_CYCLE);
    localparam int CNT_W  = cnt_width(ITER);

    state_t state_reg;
    state_t state_next;

    logic [WIDTH-1:0]  rad_reg;
    logic [REM_W-1:0]  rem_reg;
    logic [ROOT_W-1:0] root_reg;
    logic [CNT_W-1:0]  cnt_reg;
    logic [ROOT_W-1:0] root_out_reg;
`ifdef SQRT_REMAINDER_EN
    logic [ROOT_W:0]   rem_out_reg;
`endif

    logic accept;
    logic last_iter;

    logic [REM_W-1:0]  rem_chain  [BITS_PER_CYCLE+1];
    logic [ROOT_W-1:0] root_chain [BITS_PER_CYCLE+1];

    assign rem_chain[0]  = rem_reg;
    assign root_chain[0] = root_reg;

    // Steps are chained so one cycle resolves BITS_PER_CYCLE root bits,
    // consuming radicand pairs from the MSB end of the shift register.
    generate
        for (genvar gi = 0; gi < BITS_PER_CYCLE; gi++) begin : g_step
            sqrt_step #(
                .ROOT_W (ROOT_W),
                .REM_W  (REM_W)
            ) u_step (
                .rem_in   (rem_chain[gi]),
                .root_in  (root_chain[gi]),
                .pair     (rad_reg[WIDTH-1-2*gi -: 2]),
                .rem_out  (rem_chain[gi+1]),
                .root_out (root_chain[gi+1])
            );
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        accept     = 1'b0;
        last_iter  = (cnt_reg == CNT_W'(ITER - 1));
        case (state_reg)
            ST_IDLE: begin
                if (in_valid_i && !flush_i) begin
                    accept     = 1'b1;
                    state_next = ST_CALC;
                end
            end
            ST_CALC: begin
                if (last_iter) begin
                    state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                if (out_ready_i) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
        if (flush_i) begin
            state_next = ST_IDLE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rad_reg      <= '0;
            rem_reg      <= '0;
            root_reg     <= '0;
            cnt_reg      <= '0;
            root_out_reg <= '0;
`ifdef SQRT_REMAINDER_EN
            rem_out_reg  <= '0;
`endif
        end else if (flush_i) begin
            root_out_reg <= '0;
`ifdef SQRT_REMAINDER_EN
            rem_out_reg  <= '0;
`endif
        end else if (accept) begin
            rad_reg  <= valor_i;
            rem_reg  <= '0;
            root_reg <= '0;
            cnt_reg  <= '0;
        end else if (state_reg == ST_CALC) begin
            rad_reg  <= rad_reg << (2 * BITS_PER_CYCLE);
            rem_reg  <= rem_chain[BITS_PER_CYCLE];
            root_reg <= root_chain[BITS_PER_CYCLE];
            cnt_reg  <= cnt_reg + CNT_W'(1);
            // Result registers only move on completion so root_o holds in IDLE.
            if (last_iter) begin
                root_out_reg <= root_chain[BITS_PER_CYCLE];
`ifdef SQRT_REMAINDER_EN
                rem_out_reg  <= rem_chain[BITS_PER_CYCLE][ROOT_W:0];
`endif
            end
        end
    end

    assign in_ready_o  = (state_reg == ST_IDLE);
    assign out_valid_o = (state_reg == ST_DONE);
    assign busy_o      = (state_reg == ST_CALC) || (state_reg == ST_DONE);
    assign root_o      = root_out_reg;
`ifdef SQRT_REMAINDER_EN
    assign rem_o       = rem_out_reg;
`endif

endmodule
